// File: rtl/lisa_qspi_arb.sv
// Arbitrates an instruction port and a data port onto a single QSPI controller.
// An optional one-word instruction prefetch buffer is filled from word 1 of each instruction burst.
module lisa_qspi_arb #(
    parameter int CHIP_SELECTS = 2,
    parameter bit PREFETCH_EN  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_req,
    input  logic [23:0]             i_addr,
    output logic [15:0]             i_rdata,
    output logic                    i_ack,
    input  logic                    d_req,
    input  logic [23:0]             d_addr,
    input  logic [15:0]             d_wdata,
    input  logic [1:0]              d_wstrb,
    output logic [15:0]             d_rdata,
    output logic                    d_ack,
    output logic                    q_valid,
    output logic [23:0]             q_addr,
    output logic [15:0]             q_wdata,
    output logic [1:0]              q_wstrb,
    output logic [3:0]              q_xfer_len,
    input  logic                    q_ready,
    output logic                    q_ready_ack,
    input  logic                    q_xfer_done,
    input  logic [15:0]             q_rdata,
    output logic [CHIP_SELECTS-1:0] q_ce_ctrl
);

    localparam int CS_W = (CHIP_SELECTS > 1) ? $clog2(CHIP_SELECTS) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, XFER, RELEASE} state_t;

    state_t                  state_q, state_d;
    logic                    q_valid_q, q_valid_d;
    logic [23:0]             q_addr_q, q_addr_d;
    logic [15:0]             q_wdata_q, q_wdata_d;
    logic [1:0]              q_wstrb_q, q_wstrb_d;
    logic [3:0]              q_len_q, q_len_d;
    logic [CHIP_SELECTS-1:0] q_ce_q, q_ce_d;
    logic                    dport_q, dport_d;
    logic [1:0]              wcnt_q, wcnt_d;
    logic                    rdy_prev_q;
    logic [15:0]             i_rdata_q, i_rdata_d;
    logic [15:0]             d_rdata_q, d_rdata_d;
    logic                    i_ack_q, i_ack_d;
    logic                    d_ack_q, d_ack_d;
    logic                    pf_valid_q, pf_valid_d;
    logic [23:0]             pf_addr_q, pf_addr_d;
    logic [15:0]             pf_data_q, pf_data_d;
    logic [23:0]             pf_next;
    logic                    rdy_rise;
    logic                    pf_hit;
    logic                    unused_lsbs;

    function automatic logic [CS_W-1:0] cs_of(input logic [CS_W-1:0] msbs);
        return (CHIP_SELECTS > 1) ? msbs : '0;
    endfunction

    function automatic logic [CHIP_SELECTS-1:0] onehot(input logic [CS_W-1:0] idx);
        logic [CHIP_SELECTS-1:0] r;
        r = '0;
        for (int k = 0; k < CHIP_SELECTS; k++) begin
            r[k] = (idx == CS_W'(k));
        end
        return r;
    endfunction

    // Byte-address LSBs never matter: transfers are whole 16-bit words.
    assign unused_lsbs = i_addr[0] ^ d_addr[0] ^ pf_addr_q[0];

    assign rdy_rise = q_ready & ~rdy_prev_q;
    assign pf_hit   = PREFETCH_EN && pf_valid_q && (i_addr[23:1] == pf_addr_q[23:1]);

    always_comb begin
        state_d    = state_q;
        q_valid_d  = q_valid_q;
        q_addr_d   = q_addr_q;
        q_wdata_d  = q_wdata_q;
        q_wstrb_d  = q_wstrb_q;
        q_len_d    = q_len_q;
        q_ce_d     = q_ce_q;
        dport_d    = dport_q;
        wcnt_d     = wcnt_q;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        i_ack_d    = 1'b0;
        d_ack_d    = 1'b0;
        pf_valid_d = pf_valid_q;
        pf_addr_d  = pf_addr_q;
        pf_data_d  = pf_data_q;
        pf_next    = q_addr_q + 24'd2;

        case (state_q)
            IDLE: begin
                if (d_req) begin
                    if (!q_ready) begin
                        dport_d   = 1'b1;
                        q_addr_d  = {d_addr[23:1], 1'b0};
                        q_wdata_d = d_wdata;
                        q_wstrb_d = d_wstrb;
                        q_len_d   = 4'd0;
                        q_ce_d    = onehot(cs_of(d_addr[23 -: CS_W]));
                        q_valid_d = 1'b1;
                        state_d   = ISSUE;
                        if ((d_wstrb != 2'b00) && (d_addr[23:1] == pf_addr_q[23:1])) begin
                            pf_valid_d = 1'b0;
                        end
                    end
                end else if (i_req && !i_ack_q) begin
                    // i_ack_q blocks a second ack while the requester still holds i_req.
                    if (pf_hit) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = pf_data_q;
                    end else if (!q_ready) begin
                        dport_d    = 1'b0;
                        q_addr_d   = {i_addr[23:1], 1'b0};
                        q_wstrb_d  = 2'b00;
                        q_len_d    = PREFETCH_EN ? 4'd1 : 4'd0;
                        q_ce_d     = onehot(cs_of(i_addr[23 -: CS_W]));
                        q_valid_d  = 1'b1;
                        pf_valid_d = 1'b0;
                        state_d    = ISSUE;
                    end
                end
            end
            ISSUE: begin
                wcnt_d  = 2'd0;
                state_d = XFER;
            end
            XFER: begin
                if (rdy_rise) begin
                    if (wcnt_q == 2'd0) begin
                        if (!dport_q) begin
                            i_rdata_d = q_rdata;
                        end else if (q_wstrb_q == 2'b00) begin
                            d_rdata_d = q_rdata;
                        end
                    end else if ((wcnt_q == 2'd1) && !dport_q && PREFETCH_EN) begin
                        pf_data_d  = q_rdata;
                        pf_addr_d  = pf_next;
                        pf_valid_d = (cs_of(pf_next[23 -: CS_W]) == cs_of(q_addr_q[23 -: CS_W]));
                    end
                    if (wcnt_q != 2'd3) begin
                        wcnt_d = wcnt_q + 2'd1;
                    end
                end
                if (q_xfer_done) begin
                    q_valid_d = 1'b0;
                    state_d   = RELEASE;
                    if (dport_q) begin
                        d_ack_d = 1'b1;
                    end else begin
                        i_ack_d = 1'b1;
                    end
                end
            end
            RELEASE: begin
                if (!q_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                q_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            q_valid_q  <= 1'b0;
            q_addr_q   <= '0;
            q_wstrb_q  <= '0;
            q_len_q    <= '0;
            q_ce_q     <= '0;
            dport_q    <= 1'b0;
            wcnt_q     <= '0;
            rdy_prev_q <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            i_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            pf_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            q_valid_q  <= q_valid_d;
            q_addr_q   <= q_addr_d;
            q_wstrb_q  <= q_wstrb_d;
            q_len_q    <= q_len_d;
            q_ce_q     <= q_ce_d;
            dport_q    <= dport_d;
            wcnt_q     <= wcnt_d;
            rdy_prev_q <= q_ready;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            i_ack_q    <= i_ack_d;
            d_ack_q    <= d_ack_d;
            pf_valid_q <= pf_valid_d;
        end
    end

    // Pure data holders: only meaningful alongside a valid flag or state.
    always_ff @(posedge clk) begin
        q_wdata_q <= q_wdata_d;
        pf_addr_q <= pf_addr_d;
        pf_data_q <= pf_data_d;
    end

    assign q_ready_ack = dport_q && (q_wstrb_q != 2'b00) && ((state_q == ISSUE) || (state_q == XFER));

    assign i_rdata    = i_rdata_q;
    assign i_ack      = i_ack_q;
    assign d_rdata    = d_rdata_q;
    assign d_ack      = d_ack_q;
    assign q_valid    = q_valid_q;
    assign q_addr     = q_addr_q;
    assign q_wdata    = q_wdata_q;
    assign q_wstrb    = q_wstrb_q;
    assign q_xfer_len = q_len_q;
    assign q_ce_ctrl  = q_ce_q;

endmodule

// File: tb/tb_lisa_qspi_arb.sv
// Bench for lisa_qspi_arb: directed scenarios plus random traffic against a
// transaction-level model of the prefetch buffer and read-data registers.
module tb_lisa_qspi_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, q_ready, q_xfer_done, q_ready_ack;
    logic [23:0] i_addr, d_addr, q_addr;
    logic [15:0] i_rdata, d_rdata, d_wdata, q_wdata, q_rdata;
    logic        i_ack, d_ack, q_valid;
    logic [1:0]  d_wstrb, q_wstrb, q_ce_ctrl;
    logic [3:0]  q_xfer_len;

    int n_cmp = 0;
    int n_err = 0;

    // Transaction-level model state
    logic        pf_valid_m;
    logic [23:0] pf_addr_m;
    logic [15:0] pf_data_m, i_rdata_m, d_rdata_m;

    lisa_qspi_arb #(.CHIP_SELECTS(2), .PREFETCH_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .q_valid(q_valid), .q_addr(q_addr), .q_wdata(q_wdata), .q_wstrb(q_wstrb),
        .q_xfer_len(q_xfer_len), .q_ready(q_ready), .q_ready_ack(q_ready_ack),
        .q_xfer_done(q_xfer_done), .q_rdata(q_rdata), .q_ce_ctrl(q_ce_ctrl)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] ce_of(input logic [23:0] a);
        return a[23] ? 2'b10 : 2'b01;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_q_valid"}, q_valid, 0);
        chk({tag, "_q_wstrb"}, q_wstrb, 0);
        chk({tag, "_q_addr"}, q_addr, 0);
        chk({tag, "_q_xfer_len"}, q_xfer_len, 0);
        chk({tag, "_q_ready_ack"}, q_ready_ack, 0);
        chk({tag, "_q_ce_ctrl"}, q_ce_ctrl, 0);
        chk({tag, "_i_ack"}, i_ack, 0);
        chk({tag, "_d_ack"}, d_ack, 0);
        chk({tag, "_i_rdata"}, i_rdata, 0);
        chk({tag, "_d_rdata"}, d_rdata, 0);
    endtask

    // Controller side of one burst; entered at the negedge of the ISSUE cycle,
    // returns at the negedge of the cycle in which the ack is expected.
    task automatic burst(input int nw, input logic [15:0] w0, input logic [15:0] w1,
                         input int hold, input logic wr);
        @(negedge clk);
        chk("xfer_q_valid", q_valid, 1);
        chk("xfer_q_ready_ack", q_ready_ack, wr);
        @(negedge clk);
        for (int k = 0; k < nw; k++) begin
            q_rdata = (k == 0) ? w0 : w1;
            q_ready = 1'b1;
            @(negedge clk);
            if (!((k == nw - 1) && (hold > 0))) begin
                q_ready = 1'b0;
                @(negedge clk);
            end
        end
        q_xfer_done = 1'b1;
        @(negedge clk);
        q_xfer_done = 1'b0;
    endtask

    task automatic finish_release(input int hold);
        if (hold == 0) begin
            @(negedge clk);
            chk("ack_pulse_i", i_ack, 0);
            chk("ack_pulse_d", d_ack, 0);
        end else begin
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                chk("release_q_valid", q_valid, 0);
                chk("release_acks", {i_ack, d_ack}, 0);
            end
            q_ready = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic do_instr(input logic [23:0] a, input logic [15:0] w0, input logic [15:0] w1,
                            input int hold);
        logic        hit;
        logic [23:0] qa;
        hit = pf_valid_m && (a[23:1] == pf_addr_m[23:1]);
        qa  = {a[23:1], 1'b0};
        i_req  = 1'b1;
        i_addr = a;
        @(negedge clk);
        if (hit) begin
            chk("pf_hit_ack", i_ack, 1);
            chk("pf_hit_q_valid", q_valid, 0);
            chk("pf_hit_rdata", i_rdata, pf_data_m);
            i_rdata_m = pf_data_m;
            i_req = 1'b0;
            @(negedge clk);
            chk("pf_hit_ack_pulse", i_ack, 0);
            chk("pf_hit_q_valid2", q_valid, 0);
        end else begin
            chk("imiss_q_valid", q_valid, 1);
            chk("imiss_q_addr", q_addr, qa);
            chk("imiss_xfer_len", q_xfer_len, 1);
            chk("imiss_ce", q_ce_ctrl, ce_of(a));
            chk("imiss_wstrb", q_wstrb, 0);
            chk("imiss_no_early_ack", i_ack, 0);
            burst(2, w0, w1, hold, 1'b0);
            chk("imiss_ack", i_ack, 1);
            chk("imiss_no_d_ack", d_ack, 0);
            chk("imiss_q_valid_fall", q_valid, 0);
            chk("imiss_rdata", i_rdata, w0);
            i_rdata_m  = w0;
            pf_addr_m  = qa + 24'd2;
            pf_valid_m = (pf_addr_m[23] == a[23]);
            pf_data_m  = w1;
            i_req = 1'b0;
            finish_release(hold);
        end
    endtask

    task automatic do_data(input logic [23:0] da, input logic [1:0] strb, input logic [15:0] wd,
                           input logic [15:0] w0, input logic ipend, input logic [23:0] ia,
                           input int hold);
        logic [15:0] r0, r1;
        d_req   = 1'b1;
        d_addr  = da;
        d_wdata = wd;
        d_wstrb = strb;
        if (ipend) begin
            i_req  = 1'b1;
            i_addr = ia;
        end
        @(negedge clk);
        chk("data_q_valid", q_valid, 1);
        chk("data_q_addr", q_addr, {da[23:1], 1'b0});
        chk("data_xfer_len", q_xfer_len, 0);
        chk("data_ce", q_ce_ctrl, ce_of(da));
        chk("data_wstrb", q_wstrb, strb);
        chk("data_q_ready_ack", q_ready_ack, strb != 2'b00);
        chk("data_no_i_ack", i_ack, 0);
        if (strb != 2'b00) begin
            chk("data_wdata", q_wdata, wd);
            if (da[23:1] == pf_addr_m[23:1]) pf_valid_m = 1'b0;
        end
        burst(1, w0, 16'h0000, hold, strb != 2'b00);
        chk("data_ack", d_ack, 1);
        chk("data_no_i_ack2", i_ack, 0);
        chk("data_q_valid_fall", q_valid, 0);
        if (strb == 2'b00) d_rdata_m = w0;
        chk("data_rdata", d_rdata, d_rdata_m);
        chk("data_i_rdata_hold", i_rdata, i_rdata_m);
        d_req = 1'b0;
        finish_release(hold);
        if (ipend) begin
            r0 = 16'($urandom);
            r1 = 16'($urandom);
            do_instr(ia, r0, r1, 0);
        end
    endtask

    function automatic logic [23:0] pick_addr();
        case ($urandom_range(0, 5))
            0: return pf_addr_m;
            1: return pf_addr_m | 24'd1;
            2: return 24'($urandom) & 24'h0003FF;
            3: return 24'h800000 | (24'($urandom) & 24'h0003FF);
            4: return 24'h7FFFFE;
            default: return 24'hFFFFFE;
        endcase
    endfunction

    initial begin
        logic [23:0] a, ia;
        logic [15:0] w0, w1, wd;
        logic [1:0]  st;
        logic        ip;
        int          hold;

        rst_n = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        q_ready = 1'b0; q_xfer_done = 1'b0; q_rdata = '0;
        pf_valid_m = 1'b0; pf_addr_m = '0; pf_data_m = '0;
        i_rdata_m = '0; d_rdata_m = '0;

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Instruction miss fills prefetch, then hit on the next word
        do_instr(24'h000100, 16'hA1B2, 16'hC3D4, 0);
        chk("pf_addr_after_miss", pf_addr_m, 24'h000102);
        do_instr(24'h000102, 16'h0000, 16'h0000, 0);

        // Write to the prefetched word invalidates it; the re-fetch misses
        do_data(24'h000102, 2'b11, 16'h1234, 16'h0000, 1'b0, 24'h0, 0);
        do_instr(24'h000102, 16'h5566, 16'h7788, 0);

        // Simultaneous requests: data first on CS1, instruction after release
        do_data(24'h800010, 2'b00, 16'h0000, 16'hBEEF, 1'b1, 24'h000200, 0);

        // q_ready held high after completion with an instruction pending
        do_data(24'h000400, 2'b00, 16'h0000, 16'h4242, 1'b1, 24'h000500, 5);

        // Prefetch must not cross the CS boundary or the top-of-space wrap
        do_instr(24'h7FFFFE, 16'h1111, 16'h2222, 0);
        do_instr(24'h800000, 16'h3333, 16'h4444, 0);
        do_instr(24'hFFFFFE, 16'h5555, 16'h6666, 0);
        do_instr(24'h000000, 16'h7777, 16'h8888, 0);
        do_instr(24'h000301, 16'h9999, 16'hAAAA, 0);

        // Reset in the middle of a transfer
        i_req = 1'b1; i_addr = 24'h000300;
        @(negedge clk);
        @(negedge clk);
        q_rdata = 16'h5A5A; q_ready = 1'b1; rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midxfer_reset");
        rst_n = 1'b1; i_req = 1'b0; q_xfer_done = 1'b1;
        @(negedge clk);
        q_xfer_done = 1'b0;
        pf_valid_m = 1'b0; i_rdata_m = '0; d_rdata_m = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_reset_no_ack", {i_ack, d_ack}, 0);
        end
        i_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_reset_wait_ready", q_valid, 0);
        end
        q_ready = 1'b0;
        do_instr(24'h000300, 16'hCAFE, 16'hF00D, 0);

        // Random traffic
        for (int n = 0; n < 40; n++) begin
            a    = pick_addr();
            ia   = pick_addr();
            w0   = 16'($urandom);
            w1   = 16'($urandom);
            wd   = 16'($urandom);
            st   = 2'($urandom_range(0, 3));
            ip   = 1'($urandom_range(0, 1));
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            if ($urandom_range(0, 1) == 0) do_instr(a, w0, w1, hold);
            else do_data(a, st, wd, w0, ip, ia, hold);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
